seg7_scan_driver: RTL and testbench

Parametrised time-multiplexed seven-segment display driver for N_DIGITS hexadecimal digits, with per-digit decimal points, leading-zero blanking and 16-level PWM brightness. It replaces the fixed SEG/AN outputs of the processor top level. Loaded values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_driver_if.sv | 33 +++
 rtl/seg7_scan_driver.sv | 222 ++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundle between a controller and the seven-segment scan driver.
//   master : drives ena, load, value, dp_mask, blank_lz, brightness;
//            observes seg, dp, an, frame_tick
//   slave  : the scan driver (opposite directions)
// value packs one hex nibble per digit, value[3:0] = digit 0 (rightmost).
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic                  ena;
  logic                  load;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_mask;
  logic                  blank_lz;
  logic [3:0]            brightness;

  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

  modport master (
    output ena, load, value, dp_mask, blank_lz, brightness,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  ena, load, value, dp_mask, blank_lz, brightness,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for N_DIGITS hex digits with per-digit decimal
// points, leading-zero blanking and 16-level PWM brightness.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : seg7_scan_driver_if.slave
//            ena        display enable (0 blanks anodes, scan keeps running)
//            load       one-cycle strobe capturing value/dp_mask/blank_lz
//            value      hex nibbles, value[3:0] = digit 0
//            dp_mask    decimal point enable per digit
//            blank_lz   leading-zero blanking enable
//            brightness PWM duty, (brightness+1)/16 of each digit slot
//            seg        segments {g,f,e,d,c,b,a}
//            dp         decimal point
//            an         one-hot digit enable
//            frame_tick one-cycle pulse in the cycle the digit index wraps
//
// Scan timing: prescaler 0..PRESCALE-1 -> sub-tick 0..15 -> digit index
// 0..N_DIGITS-1. Loads are parked in a pending copy and moved to the display
// copy only when the index wraps, so a frame never mixes old and new data.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sub_q, sub_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          presc_wrap, sub_wrap, frame_wrap;
  logic          frame_wrap_next;

  always_comb begin
    presc_wrap = (presc_q == PRESC_LAST);
    sub_wrap   = presc_wrap && (sub_q == 4'hF);
    frame_wrap = sub_wrap && (idx_q == IDX_LAST);

    presc_d = presc_wrap ? '0 : presc_q + PW'(1);
    sub_d   = presc_wrap ? sub_q + 4'd1 : sub_q;
    idx_d   = idx_q;
    if (sub_wrap) begin
      idx_d = frame_wrap ? '0 : idx_q + IW'(1);
    end

    // Looking one cycle ahead lets the registered frame_tick sit in the very
    // cycle the index wraps, so a load issued while frame_tick is high lands
    // at that boundary.
    frame_wrap_next = (presc_d == PRESC_LAST) && (sub_d == 4'hF) &&
                      (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sub_q   <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / display double buffer
  // ---------------------------------------------------------------------------
  logic [VW-1:0]       pend_value_q, disp_value_q;
  logic [N_DIGITS-1:0] pend_dp_q, disp_dp_q;
  logic                pend_blz_q, disp_blz_q;
  logic                pend_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blz_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_blz_q   <= 1'b0;
    end else if (frame_wrap) begin
      pend_valid_q <= 1'b0;
      // A load in the boundary cycle bypasses the pending copy and wins
      // over anything still parked there.
      if (bus.load) begin
        disp_value_q <= bus.value;
        disp_dp_q    <= bus.dp_mask;
        disp_blz_q   <= bus.blank_lz;
      end else if (pend_valid_q) begin
        disp_value_q <= pend_value_q;
        disp_dp_q    <= pend_dp_q;
        disp_blz_q   <= pend_blz_q;
      end
    end else if (bus.load) begin
      pend_value_q <= bus.value;
      pend_dp_q    <= bus.dp_mask;
      pend_blz_q   <= bus.blank_lz;
      pend_valid_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking: walk down from the top digit, a digit is blanked
  // while every nibble from it upwards is zero. Digit 0 always shows.
  // ---------------------------------------------------------------------------
  logic                upper_zero;
  logic [N_DIGITS-1:0] blanked;

  always_comb begin
    upper_zero = 1'b1;
    blanked    = '0;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      upper_zero = upper_zero & (disp_value_q[4*d +: 4] == 4'h0);
      if (d != 0) begin
        blanked[d] = disp_blz_q & upper_zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit select and lit decision (active-high)
  // ---------------------------------------------------------------------------
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [N_DIGITS-1:0] cur_onehot;
  logic                lit;
  logic [6:0]          seg_raw;
  logic                dp_raw;
  logic [N_DIGITS-1:0] an_raw;

  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        cur_nib       = disp_value_q[4*d +: 4];
        cur_dp        = disp_dp_q[d];
        cur_blank     = blanked[d];
        cur_onehot[d] = 1'b1;
      end
    end

    // brightness is used live so a change takes effect mid-frame.
    lit     = bus.ena && (sub_q <= bus.brightness) && !cur_blank;
    seg_raw = lit ? hex_to_seg(cur_nib) : 7'h00;
    dp_raw  = lit & cur_dp;
    an_raw  = lit ? cur_onehot : '0;
  end

  // ---------------------------------------------------------------------------
  // Output registers; polarity is applied only here.
  // ---------------------------------------------------------------------------
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIGITS-1:0] an_q;
  logic                frame_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= {7{SEG_ACTIVE_LOW}};
      dp_q         <= SEG_ACTIVE_LOW;
      an_q         <= {N_DIGITS{AN_ACTIVE_LOW}};
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
      dp_q         <= dp_raw ^ SEG_ACTIVE_LOW;
      an_q         <= an_raw ^ {N_DIGITS{AN_ACTIVE_LOW}};
      frame_tick_q <= frame_wrap_next;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver (N_DIGITS=4, PRESCALE=2, active-low).
// The driver computes what the display must show from the absolute scan
// position (cycle count within a frame) and a buffered copy of the loaded
// data, pushes it into a queue, and a monitor on the falling edge pops and
// compares every cycle.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int PS    = 2;
  localparam int SLOT  = 16 * PS;
  localparam int FRAME = ND * SLOT;

  typedef struct packed {
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          ft;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .N_DIGITS      (ND),
    .PRESCALE      (PS),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  obs_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   mon_en     = 1'b0;

  // Reference state: scan position and the two data copies.
  int           pos;
  logic [15:0]  m_val, p_val;
  logic [ND-1:0] m_dp, p_dp;
  logic         m_blz, p_blz, p_valid;

  localparam obs_t OFF = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, ft: 1'b0};

  function automatic obs_t model_out(input int p);
    obs_t        o;
    int          digit, sub;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [3:0]  one;
    bit          blanked, lit;
    digit   = p / SLOT;
    sub     = (p / PS) % 16;
    upper   = m_val >> (4 * digit);
    nib     = upper[3:0];
    blanked = m_blz && (digit != 0) && (upper == 16'h0);
    lit     = (bus.ena == 1'b1) && (sub <= int'(bus.brightness)) && !blanked;
    one     = 4'b0001 << digit;
    o       = OFF;
    if (lit) begin
      o.seg = ~hex_tbl[nib];
      o.dp  = ~m_dp[digit];
      o.an  = ~one;
    end
    return o;
  endfunction

  // One clock of stimulus: record what the next cycle must show, then let
  // the reference data copies follow the load/boundary rules.
  task automatic cycle();
    obs_t e;
    e    = model_out(pos);
    e.ft = (((pos + 1) % FRAME) == FRAME - 1);
    exp_q.push_back(e);
    if (pos == FRAME - 1) begin
      if (bus.load) begin
        m_val = bus.value; m_dp = bus.dp_mask; m_blz = bus.blank_lz;
      end else if (p_valid) begin
        m_val = p_val; m_dp = p_dp; m_blz = p_blz;
      end
      p_valid = 1'b0;
    end else if (bus.load) begin
      p_val = bus.value; p_dp = bus.dp_mask; p_blz = bus.blank_lz;
      p_valid = 1'b1;
    end
    pos = (pos + 1) % FRAME;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [ND-1:0] m, input logic b);
    bus.value    = v;
    bus.dp_mask  = m;
    bus.blank_lz = b;
    bus.load     = 1'b1;
    cycle();
  endtask

  task automatic run_to_boundary();
    int guard = 0;
    while (pos != FRAME - 1 && guard < FRAME) begin
      cycle();
      guard++;
    end
  endtask

  task automatic check_off(input string name);
    obs_t a;
    a = '{seg: bus.seg, dp: bus.dp, an: bus.an, ft: bus.frame_tick};
    vectors++;
    if (a !== OFF) begin
      miscompares++;
      $display("FAIL %s got seg=%h dp=%b an=%h ft=%b, expected seg=%h dp=%b an=%h ft=%b",
               name, a.seg, a.dp, a.an, a.ft, OFF.seg, OFF.dp, OFF.an, OFF.ft);
    end
  endtask

  // Assert reset at the current point, check the cleared outputs, release.
  task automatic do_reset();
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    bus.load = 1'b0;
    exp_q.delete();
    pos     = 0;
    m_val   = '0; m_dp = '0; m_blz = 1'b0;
    p_val   = '0; p_dp = '0; p_blz = 1'b0; p_valid = 1'b0;
    #1;
    check_off("reset_immediate");
    @(negedge clk);
    check_off("reset_hold");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_off("reset_hold_late");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(OFF);
    mon_en = 1'b1;
  endtask

  // Monitor: compares every cycle the DUT output against the queued value.
  obs_t mon_e, mon_a;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_empty at t=%0t got nothing queued, expected one entry", $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = '{seg: bus.seg, dp: bus.dp, an: bus.an, ft: bus.frame_tick};
          if (mon_a !== mon_e) begin
            miscompares++;
            $display("FAIL scan_out t=%0t got seg=%h dp=%b an=%h ft=%b, expected seg=%h dp=%b an=%h ft=%b",
                     $time, mon_a.seg, mon_a.dp, mon_a.an, mon_a.ft,
                     mon_e.seg, mon_e.dp, mon_e.an, mon_e.ft);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] rv, mask;
    rst_n          = 1'b0;
    bus.ena        = 1'b0;
    bus.load       = 1'b0;
    bus.value      = '0;
    bus.dp_mask    = '0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 4'hF;
    @(posedge clk);
    #1;
    do_reset();

    // Scan order and frame_tick period
    bus.ena = 1'b1;
    do_load(16'h12AF, 4'b0000, 1'b0);
    run(3 * FRAME);

    // Double buffer: last load before the boundary wins
    run(40);
    do_load(16'h1111, 4'b0001, 1'b0);
    run(30);
    do_load(16'h2222, 4'b0010, 1'b0);
    run_to_boundary();
    run(FRAME);

    // Load in the frame_tick cycle goes straight to display
    run_to_boundary();
    do_load(16'hABCD, 4'b0110, 1'b0);
    run(FRAME + 10);

    // Leading-zero blanking
    do_load(16'h0050, 4'b1001, 1'b1);
    run(2 * FRAME);
    do_load(16'h0000, 4'b1111, 1'b1);
    run(2 * FRAME);

    // Brightness
    do_load(16'h8421, 4'b0000, 1'b0);
    bus.brightness = 4'd3;
    run(2 * FRAME);
    bus.brightness = 4'd0;
    run(2 * FRAME);
    bus.brightness = 4'hF;

    // ena dropped mid-slot
    run(20);
    bus.ena = 1'b0;
    run(50);
    bus.ena = 1'b1;
    run(FRAME);

    // Reset with a load still pending
    run(30);
    do_load(16'h9999, 4'hF, 1'b0);
    run(10);
    do_reset();
    run(2 * FRAME);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 99) == 0) bus.ena = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) bus.brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        rv   = 16'($urandom_range(0, 65535));
        mask = 16'hFFFF >> (4 * $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) rv = rv & mask;
        bus.value    = rv;
        bus.dp_mask  = 4'($urandom_range(0, 15));
        bus.blank_lz = 1'($urandom_range(0, 1));
        bus.load     = 1'b1;
      end
      cycle();
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
